// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with hold-limit preemption and a registered one-hot grant.
// Optional one-hot checker on err_o is built when ARB_ONEHOT_CHECK_EN is defined.
module rr_grant_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       gnt_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
    output logic                       err_o
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                gnt_valid_q;
    logic [IDW-1:0]      gnt_id_q;
    logic [IDW-1:0]      ptr_q;
    logic [HW-1:0]       hold_q;

    logic [NUM_REQ-1:0]  cand;
    logic                found;
    logic [IDW-1:0]      pick;
    logic                keep;
    logic [IDW-1:0]      ptr_d;

    // Candidates exclude the current owner; in IDLE gnt_q is zero so all requests qualify.
    assign cand = req_i & ~gnt_q;

    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    assign keep  = (state_q == GRANT) && req_i[gnt_id_q] &&
                   !((hold_q == HW'(MAX_HOLD)) && found);
    assign ptr_d = (pick == IDW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else if (keep) begin
            hold_q <= (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
        end else if (found) begin
            // New owner (fresh grant, release handoff or preemption): no dead cycle.
            state_q         <= GRANT;
            gnt_q           <= '0;
            gnt_q[pick]     <= 1'b1;
            gnt_valid_q     <= 1'b1;
            gnt_id_q        <= pick;
            ptr_q           <= ptr_d;
            hold_q          <= HW'(1);
        end else begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hold_q      <= '0;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_id_o    = gnt_id_q;

`ifdef ARB_ONEHOT_CHECK_EN
    logic err_q;
    logic multi_hot;
    logic vld_mismatch;

    assign multi_hot    = (gnt_q != '0) && ((gnt_q & (gnt_q - 1'b1)) != '0);
    assign vld_mismatch = gnt_valid_q != (gnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (multi_hot || vld_mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
